// File: rtl/vgm_sequencer.sv
// vgm_sequencer: decodes a VGM command byte stream into PSG/OPLL register
// writes and sample waits. Each wait is loaded into an external sample timer
// with a low-byte write followed by a high-byte/start write, and the
// sequencer stalls until the timer reports that it is no longer counting.
module vgm_sequencer #(
    parameter logic [7:0] OPLL_CMD = 8'h51,
    parameter logic [7:0] PSG_CMD  = 8'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       chip_wr_o,
    output logic       chip_sel_o,
    output logic [7:0] chip_adr_o,
    output logic [7:0] chip_data_o,
    output logic       tmr_wr_o,
    output logic       tmr_adr_o,
    output logic [7:0] tmr_data_o,
    input  logic       tmr_active_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_OP     = 4'd1,
        ST_ARG1   = 4'd2,
        ST_ARG2   = 4'd3,
        ST_CHIPWR = 4'd4,
        ST_TLO    = 4'd5,
        ST_THI    = 4'd6,
        ST_WAIT   = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } state_e;

    localparam logic [7:0] OP_WAIT_N  = 8'h61;
    localparam logic [7:0] OP_WAIT_60 = 8'h62;
    localparam logic [7:0] OP_WAIT_50 = 8'h63;
    localparam logic [7:0] OP_END     = 8'h66;

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  arg1_q, arg1_d;
    logic [15:0] count_q, count_d;
    logic        chip_sel_q, chip_sel_d;
    logic [7:0]  chip_adr_q, chip_adr_d;
    logic [7:0]  chip_data_q, chip_data_d;
    logic        tmr_adr_q, tmr_adr_d;
    logic [7:0]  tmr_data_q, tmr_data_d;
    logic        in_ready_q, in_ready_d;
    logic        chip_wr_q, chip_wr_d;
    logic        tmr_wr_q, tmr_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer_s;

    // A byte moves only when the registered ready flag meets valid input.
    assign xfer_s = in_valid_i & in_ready_q;

    // Next-state decode, operand capture and output-register next values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg1_d      = arg1_q;
        count_d     = count_q;
        chip_sel_d  = chip_sel_q;
        chip_adr_d  = chip_adr_q;
        chip_data_d = chip_data_q;
        tmr_adr_d   = tmr_adr_q;
        tmr_data_d  = tmr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_OP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_OP: begin
                if (xfer_s) begin
                    op_d = in_data_i;
                    if ((in_data_i == PSG_CMD) || (in_data_i == OPLL_CMD) ||
                        (in_data_i == OP_WAIT_N)) begin
                        state_d = ST_ARG1;
                    end else if (in_data_i == OP_WAIT_60) begin
                        count_d = 16'h02DF;
                        state_d = ST_TLO;
                    end else if (in_data_i == OP_WAIT_50) begin
                        count_d = 16'h0372;
                        state_d = ST_TLO;
                    end else if (in_data_i[7:4] == 4'h7) begin
                        count_d = {12'h000, in_data_i[3:0]} + 16'h0001;
                        state_d = ST_TLO;
                    end else if (in_data_i == OP_END) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_OP;
                end
            end
            ST_ARG1: begin
                if (xfer_s) begin
                    arg1_d = in_data_i;
                    if (op_q == PSG_CMD) begin
                        chip_sel_d  = 1'b0;
                        chip_adr_d  = 8'h00;
                        chip_data_d = in_data_i;
                        state_d     = ST_CHIPWR;
                    end else begin
                        state_d = ST_ARG2;
                    end
                end else begin
                    state_d = ST_ARG1;
                end
            end
            ST_ARG2: begin
                if (xfer_s) begin
                    if (op_q == OPLL_CMD) begin
                        chip_sel_d  = 1'b1;
                        chip_adr_d  = arg1_q;
                        chip_data_d = in_data_i;
                        state_d     = ST_CHIPWR;
                    end else begin
                        // Explicit wait: count is little-endian {arg2, arg1}.
                        count_d = {in_data_i, arg1_q};
                        state_d = ST_TLO;
                    end
                end else begin
                    state_d = ST_ARG2;
                end
            end
            ST_CHIPWR: state_d = ST_OP;
            ST_TLO:    state_d = ST_THI;
            ST_THI:    state_d = ST_WAIT;
            ST_WAIT: begin
                if (tmr_active_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_OP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timer data is loaded on entry to each timer-write state, held otherwise.
        if (state_d == ST_TLO) begin
            tmr_adr_d  = 1'b0;
            tmr_data_d = count_d[7:0];
        end else if (state_d == ST_THI) begin
            tmr_adr_d  = 1'b1;
            tmr_data_d = count_q[15:8];
        end else begin
            tmr_adr_d  = tmr_adr_q;
            tmr_data_d = tmr_data_q;
        end

        // Flags are registered from the next state so they track state exactly.
        in_ready_d = (state_d == ST_OP) || (state_d == ST_ARG1) || (state_d == ST_ARG2);
        chip_wr_d  = (state_d == ST_CHIPWR);
        tmr_wr_d   = (state_d == ST_TLO) || (state_d == ST_THI);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    // State, operand and output registers; reset drops every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 8'h00;
            arg1_q      <= 8'h00;
            count_q     <= 16'h0000;
            chip_sel_q  <= 1'b0;
            chip_adr_q  <= 8'h00;
            chip_data_q <= 8'h00;
            tmr_adr_q   <= 1'b0;
            tmr_data_q  <= 8'h00;
            in_ready_q  <= 1'b0;
            chip_wr_q   <= 1'b0;
            tmr_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg1_q      <= arg1_d;
            count_q     <= count_d;
            chip_sel_q  <= chip_sel_d;
            chip_adr_q  <= chip_adr_d;
            chip_data_q <= chip_data_d;
            tmr_adr_q   <= tmr_adr_d;
            tmr_data_q  <= tmr_data_d;
            in_ready_q  <= in_ready_d;
            chip_wr_q   <= chip_wr_d;
            tmr_wr_q    <= tmr_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign chip_wr_o   = chip_wr_q;
    assign chip_sel_o  = chip_sel_q;
    assign chip_adr_o  = chip_adr_q;
    assign chip_data_o = chip_data_q;
    assign tmr_wr_o    = tmr_wr_q;
    assign tmr_adr_o   = tmr_adr_q;
    assign tmr_data_o  = tmr_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
